// File: rtl/downsampler_pkg.sv
// downsampler_pkg: shared definitions for the symbol downsampler and its
// benches (the upsampler bench uses the same OSR default so both sides match).
//   ds_state_t      - receiver FSM states
//   DS_OSR          - default samples per symbol period
//   DS_DW           - default sample/symbol width
//   DS_ACQ_SYMBOLS  - default acquisition length in symbol periods
//   DS_PHASE_W      - width of phase indices (covers OSR up to 16)
package downsampler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    SELECT,
    TRACK
  } ds_state_t;

  localparam int unsigned DS_OSR         = 13;
  localparam int unsigned DS_DW          = 4;
  localparam int unsigned DS_ACQ_SYMBOLS = 16;
  localparam int unsigned DS_PHASE_W     = 4;

endpackage

// File: rtl/downsampler_phase_argmax.sv
// phase_argmax: sequential argmax over N unsigned accumulators, one entry per
// clock. Holding go high runs the search; done is high on the N-th cycle of
// go, together with the winning index on idx. Dropping go aborts the search.
// Strict greater-than: ties keep the lowest index, all-zero selects index 0.
//   clk, rst  - clock, asynchronous active-high reset
//   go        - run request (level)
//   acc       - accumulator array, entry i is phase i
//   done      - result valid this cycle
//   idx       - winning index (valid while done)
module phase_argmax
  import downsampler_pkg::*;
#(
  parameter int unsigned N  = DS_OSR,
  parameter int unsigned W  = 8,
  parameter int unsigned IW = DS_PHASE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic [N-1:0][W-1:0] acc,
  output logic                done,
  output logic [IW-1:0]       idx
);

  logic          busy;
  logic [IW-1:0] cnt;
  logic [IW-1:0] best_idx;
  logic [W-1:0]  best_val;
  logic [W-1:0]  cur;
  logic          last;
  logic          better;

  always_comb begin
    cur = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt == IW'(i)) cur = acc[i];
    end
  end

  assign last   = (cnt == IW'(N - 1));
  assign better = (cur > best_val);

  // The last entry is resolved combinationally so the whole search spans
  // exactly N cycles of go: cycle 1 loads entry 0, cycles 2..N compare 1..N-1.
  assign done = busy && last;
  assign idx  = better ? cnt : best_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      cnt      <= '0;
      best_idx <= '0;
      best_val <= '0;
    end else if (!go) begin
      busy <= 1'b0;
    end else if (!busy) begin
      busy     <= 1'b1;
      cnt      <= IW'(1);
      best_val <= acc[0];
      best_idx <= '0;
    end else if (!last) begin
      if (better) begin
        best_val <= cur;
        best_idx <= cnt;
      end
      cnt <= cnt + IW'(1);
    end else begin
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/downsampler.sv
// downsampler: acquires symbol timing on an oversampled stream by summing
// |sample| per phase over ACQ_SYMBOLS periods, picks the strongest phase and
// then emits one symbol per period with a single-cycle strobe.
//   clk, rst      - clock, asynchronous active-high reset
//   start         - pulse, (re)start acquisition; overrides everything
//   sample_valid  - sample_in valid this cycle
//   sample_in     - signed sample
//   symbol_out    - decimated symbol, held between strobes
//   symbol_valid  - one-cycle strobe, symbol_out new
//   locked        - timing acquired (tracking)
//   best_phase    - selected phase index
module downsampler
  import downsampler_pkg::*;
#(
  parameter int unsigned OSR         = DS_OSR,
  parameter int unsigned DW          = DS_DW,
  parameter int unsigned ACQ_SYMBOLS = DS_ACQ_SYMBOLS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_in,
  output logic [DW-1:0] symbol_out,
  output logic          symbol_valid,
  output logic          locked,
  output logic [3:0]    best_phase
);

  localparam int unsigned ACC_W = DW + $clog2(ACQ_SYMBOLS);
  localparam int unsigned SYM_W = (ACQ_SYMBOLS > 1) ? $clog2(ACQ_SYMBOLS) : 1;
  localparam int unsigned PH_W  = DS_PHASE_W;

  ds_state_t                   state, state_next;
  logic [PH_W-1:0]             phase_cnt;
  logic [SYM_W-1:0]            sym_cnt;
  logic [OSR-1:0][ACC_W-1:0]   acc;
  logic [DW-1:0]               mag;
  logic [ACC_W-1:0]            mag_ext;
  logic                        phase_last;
  logic                        acq_done;
  logic                        am_done;
  logic [PH_W-1:0]             am_idx;

  // Magnitude as unsigned DW bits: the most negative value maps to 2^(DW-1).
  assign mag        = sample_in[DW-1] ? ((~sample_in) + DW'(1)) : sample_in;
  assign mag_ext    = {{(ACC_W - DW){1'b0}}, mag};
  assign phase_last = (phase_cnt == PH_W'(OSR - 1));
  assign acq_done   = sample_valid && phase_last && (sym_cnt == SYM_W'(ACQ_SYMBOLS - 1));

  phase_argmax #(
    .N  (OSR),
    .W  (ACC_W),
    .IW (PH_W)
  ) u_argmax (
    .clk  (clk),
    .rst  (rst),
    .go   (state == SELECT),
    .acc  (acc),
    .done (am_done),
    .idx  (am_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ACQUIRE;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        ACQUIRE: if (acq_done) state_next = SELECT;
        SELECT:  if (am_done)  state_next = TRACK;
        TRACK:   state_next = TRACK;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_cnt    <= '0;
      sym_cnt      <= '0;
      acc          <= '0;
      symbol_out   <= '0;
      symbol_valid <= 1'b0;
      locked       <= 1'b0;
      best_phase   <= '0;
    end else begin
      symbol_valid <= 1'b0;
      locked       <= (state_next == TRACK);
      if (start) begin
        // A sample arriving with start is the first sample of phase 0.
        acc     <= '0;
        sym_cnt <= '0;
        if (sample_valid) begin
          acc[0]    <= mag_ext;
          phase_cnt <= PH_W'(1);
        end else begin
          phase_cnt <= '0;
        end
      end else begin
        if (state != IDLE && sample_valid)
          phase_cnt <= phase_last ? '0 : phase_cnt + PH_W'(1);
        case (state)
          ACQUIRE: begin
            if (sample_valid) begin
              acc[phase_cnt] <= acc[phase_cnt] + mag_ext;
              if (phase_last) sym_cnt <= sym_cnt + SYM_W'(1);
            end
          end
          SELECT: begin
            if (am_done) best_phase <= am_idx;
          end
          TRACK: begin
            if (sample_valid && phase_cnt == best_phase) begin
              symbol_out   <= sample_in;
              symbol_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_downsampler.sv
module tb_downsampler;

  localparam int OSR = 13;
  localparam int DW  = 4;
  localparam int ACQ = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          sample_valid;
  logic [DW-1:0] sample_in;
  logic [DW-1:0] symbol_out;
  logic          symbol_valid;
  logic          locked;
  logic [3:0]    best_phase;

  downsampler #(
    .OSR         (OSR),
    .DW          (DW),
    .ACQ_SYMBOLS (ACQ)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .symbol_out   (symbol_out),
    .symbol_valid (symbol_valid),
    .locked       (locked),
    .best_phase   (best_phase)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Works on the sample index since the last start: phase = n % OSR.
  int            m_mode;      // 0 idle, 1 acquiring, 2 selecting, 3 tracking
  int            m_acc[OSR];
  int            m_n;
  int            m_sel_left;
  logic [DW-1:0] e_sym;
  bit            e_val;
  bit            e_lock;
  int            e_best;

  function automatic int mag_of(input logic [DW-1:0] s);
    int v;
    v = $signed(s);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int argmax_of();
    int b;
    b = 0;
    for (int i = 1; i < OSR; i++)
      if (m_acc[i] > m_acc[b]) b = i;
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_n = 0; m_sel_left = 0;
      for (int i = 0; i < OSR; i++) m_acc[i] = 0;
      e_sym = '0; e_val = 0; e_lock = 0; e_best = 0;
    end else begin
      e_val = 0;
      if (start) begin
        m_mode = 1; m_n = 0; e_lock = 0;
        for (int i = 0; i < OSR; i++) m_acc[i] = 0;
        if (sample_valid) begin
          m_acc[0] += mag_of(sample_in);
          m_n = 1;
        end
      end else begin
        case (m_mode)
          1: if (sample_valid) begin
               m_acc[m_n % OSR] += mag_of(sample_in);
               m_n++;
               if (m_n == ACQ * OSR) begin
                 m_mode = 2;
                 m_sel_left = OSR;
               end
             end
          2: begin
               if (sample_valid) m_n++;
               m_sel_left--;
               if (m_sel_left == 0) begin
                 e_best = argmax_of();
                 e_lock = 1;
                 m_mode = 3;
               end
             end
          3: if (sample_valid) begin
               if (m_n % OSR == e_best) begin
                 e_sym = sample_in;
                 e_val = 1;
               end
               m_n++;
             end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("symbol_valid", int'(symbol_valid), int'(e_val));
      chk("symbol_out", int'(symbol_out), int'(e_sym));
      chk("locked", int'(locked), int'(e_lock));
      chk("best_phase", int'(best_phase), e_best);
    end
  end

  logic [DW-1:0] strobes[$];
  always @(negedge clk) if (!rst && symbol_valid) strobes.push_back(symbol_out);

  // ---------------- stimulus ----------------
  int pat_kind;   // 0 pulse at pat_phase, 1 tie 4/9, 2 zeros, 3 full-scale ph2, 4 random
  int pat_phase;
  int drv_n;
  int vals[4] = '{3, -3, 7, -8};

  function automatic logic [DW-1:0] gen(input int n);
    int ph, per, v;
    ph = n % OSR; per = n / OSR; v = 0;
    case (pat_kind)
      0: if (ph == pat_phase) v = vals[per % 4];
      1: if (ph == 4) v = (per % 2) ? -2 : 2;
         else if (ph == 9) v = (per % 2) ? 2 : -2;
      3: if (ph == 2) v = -8;
      4: v = $urandom_range(0, 15);
      default: v = 0;
    endcase
    return DW'(v);
  endfunction

  task automatic cyc(input bit st, input bit v);
    @(negedge clk);
    if (st) drv_n = 0;
    start        = st;
    sample_valid = v;
    if (v) begin
      sample_in = gen(drv_n);
      drv_n++;
    end else begin
      sample_in = DW'($urandom_range(0, 15));
    end
  endtask

  // Returns number of edges after the start edge at which locked was seen.
  task automatic wait_lock(input bit gapped, output int edges);
    int k;
    k = 0;
    do begin
      cyc(0, gapped ? bit'($urandom_range(0, 1)) : 1'b1);
      k++;
    end while (!locked && k < 1500);
    if (!locked) chk("lock_timeout", 0, 1);
    edges = k - 1;
  endtask

  logic [DW-1:0] ref_seq[$];
  int            e;

  initial begin
    rst = 1'b1; start = 0; sample_valid = 0; sample_in = '0; drv_n = 0;
    pat_kind = 0; pat_phase = 5;
    repeat (2) @(negedge clk);
    chk("rst_symbol_out", int'(symbol_out), 0);
    chk("rst_symbol_valid", int'(symbol_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_best_phase", int'(best_phase), 0);
    rst = 1'b0;
    repeat (20) cyc(0, 1);
    chk("idle_no_strobe", strobes.size(), 0);

    // Clean lock, phase 5, continuous
    pat_kind = 0; pat_phase = 5;
    cyc(1, 0);
    wait_lock(0, e);
    chk("clean_lock_edges", e, 221);
    chk("clean_best", int'(best_phase), 5);
    chk("model_best_clean", e_best, 5);
    strobes.delete();
    repeat (78) cyc(0, 1);
    cyc(0, 0);
    chk("clean_strobe_count", strobes.size(), 6);
    if (strobes.size() > 0) chk("clean_first_symbol", int'(strobes[0]), 13);
    ref_seq = strobes;

    // Asynchronous reset in the middle of tracking
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_locked", int'(locked), 0);
    chk("async_symbol_out", int'(symbol_out), 0);
    chk("async_best", int'(best_phase), 0);
    @(negedge clk);
    rst = 1'b0;
    strobes.delete();
    repeat (60) cyc(0, 1);
    chk("post_reset_no_strobe", strobes.size(), 0);

    // Gapped input, same pattern: same phase and symbol sequence
    cyc(1, 0);
    wait_lock(1, e);
    chk("gapped_best", int'(best_phase), 5);
    strobes.delete();
    for (int i = 0; i < 600 && strobes.size() < ref_seq.size(); i++)
      cyc(0, bit'($urandom_range(0, 1)));
    chk("gapped_strobe_count", strobes.size(), ref_seq.size());
    for (int i = 0; i < ref_seq.size() && i < strobes.size(); i++)
      chk("gapped_symbol", int'(strobes[i]), int'(ref_seq[i]));

    // Tie between phases 4 and 9
    pat_kind = 1;
    cyc(1, 0);
    wait_lock(0, e);
    chk("tie_best", int'(best_phase), 4);

    // All zero
    pat_kind = 2;
    cyc(1, 0);
    wait_lock(0, e);
    chk("zero_best", int'(best_phase), 0);
    chk("zero_locked", int'(locked), 1);

    // Full scale at phase 2
    pat_kind = 3;
    cyc(1, 0);
    wait_lock(0, e);
    chk("fullscale_best", int'(best_phase), 2);
    chk("model_acc2", m_acc[2], 128);
    repeat (30) cyc(0, 1);

    // Restart during SELECT, reacquire at phase 11
    pat_kind = 0; pat_phase = 5;
    cyc(1, 0);
    repeat (213) cyc(0, 1);
    pat_phase = 11;
    cyc(1, 1);
    wait_lock(0, e);
    chk("restart_sel_edges", e, 220);
    chk("restart_sel_best", int'(best_phase), 11);
    repeat (40) cyc(0, 1);

    // Restart during TRACK, reacquire at phase 3
    pat_phase = 3;
    cyc(1, 1);
    cyc(0, 1);
    chk("restart_trk_locked_drop", int'(locked), 0);
    chk("restart_trk_no_strobe", int'(symbol_valid), 0);
    chk("restart_trk_best_held", int'(best_phase), 11);
    wait_lock(0, e);
    chk("restart_trk_edges", e, 219);
    chk("restart_trk_best", int'(best_phase), 3);
    repeat (40) cyc(0, 1);

    // Random samples with gaps: model-only checking
    pat_kind = 4;
    cyc(1, 0);
    wait_lock(1, e);
    repeat (200) cyc(0, bit'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
